sram_bus_responder: RTL

//  Responder side of the 6502 memory bus: accepts one access per request from processor_6502
//  (memory_address/memory_data_out/read_write) and performs it on the external 16-bit async SRAM.

---
 rtl/sram_bus_responder.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/sram_bus_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sram_bus_responder : turns single-cycle 6502 bus requests into timed
//                      accesses on an external 16-bit asynchronous SRAM.
// Optional: SRAM_BUS_RESPONDER_WRITE_PROTECT_EN blocks writes at/above ROM_BASE.
// Revision: 1.0
// ----------------------------------------------------------------------------
module sram_bus_responder #(
  parameter logic [3:0]  SRAM_BANK   = 4'h0,
  parameter int unsigned ACCESS_WAIT = 2,
  parameter int          PACKED      = 0,
  parameter logic [15:0] ROM_BASE    = 16'hC000
) (
  input  logic        master_clock,
  input  logic        reset,
  input  logic        bus_request,
  input  logic [15:0] memory_address,
  input  logic [7:0]  memory_data_out,
  input  logic        read_write,
  output logic [7:0]  memory_data_in,
  output logic        bus_ready,
  output logic        bus_busy,
  output logic        bus_overrun,
  output logic [19:0] sram_address,
  inout  wire  [15:0] sram_data,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic        sram_ub_n,
  output logic        sram_lb_n
);

  localparam bit         IS_PACKED = (PACKED != 0);
  localparam logic [3:0] WAIT_LOAD = 4'(ACCESS_WAIT - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETUP   = 2'd1,
    ST_ACCESS  = 2'd2,
    ST_RECOVER = 2'd3
  } state_t;

  state_t      state;
  logic [3:0]  wait_cnt;
  logic        rd_q;
  logic        prot_q;
  logic        lane_hi_q;
  logic        drive_en;
  logic [15:0] sram_wdata;

  logic [19:0] req_sram_addr;
  logic [15:0] req_wdata;
  logic        req_lane_hi;
  logic        req_protected;

  // Packed mode stores two CPU bytes per SRAM word; address bit 0 picks the lane.
  assign req_sram_addr = IS_PACKED ? {SRAM_BANK, 1'b0, memory_address[15:1]}
                                   : {SRAM_BANK, memory_address};
  assign req_wdata     = IS_PACKED ? {memory_data_out, memory_data_out}
                                   : {8'h00, memory_data_out};
  assign req_lane_hi   = IS_PACKED && memory_address[0];

`ifdef SRAM_BUS_RESPONDER_WRITE_PROTECT_EN
  assign req_protected = !read_write && (memory_address >= ROM_BASE);
`else
  logic unused_rom_base;
  assign req_protected   = 1'b0;
  assign unused_rom_base = ^ROM_BASE;
`endif

  assign sram_data = drive_en ? sram_wdata : 16'hzzzz;

  always_ff @(posedge master_clock or negedge reset) begin
    if (!reset) begin
      state          <= ST_IDLE;
      wait_cnt       <= 4'd0;
      rd_q           <= 1'b1;
      prot_q         <= 1'b0;
      lane_hi_q      <= 1'b0;
      drive_en       <= 1'b0;
      sram_wdata     <= 16'h0000;
      sram_address   <= 20'h00000;
      sram_ce_n      <= 1'b1;
      sram_oe_n      <= 1'b1;
      sram_we_n      <= 1'b1;
      sram_ub_n      <= 1'b1;
      sram_lb_n      <= 1'b1;
      memory_data_in <= 8'h00;
      bus_ready      <= 1'b0;
      bus_busy       <= 1'b0;
      bus_overrun    <= 1'b0;
    end else begin
      bus_ready   <= 1'b0;
      // Requests are only taken in IDLE; anything else is dropped and flagged.
      bus_overrun <= bus_request && (state != ST_IDLE);
      case (state)
        ST_IDLE: begin
          if (bus_request) begin
            rd_q         <= read_write;
            prot_q       <= req_protected;
            lane_hi_q    <= req_lane_hi;
            sram_address <= req_sram_addr;
            sram_wdata   <= req_wdata;
            sram_ce_n    <= 1'b0;
            sram_oe_n    <= !read_write;
            sram_ub_n    <= !req_lane_hi;
            sram_lb_n    <= req_lane_hi;
            drive_en     <= !read_write && !req_protected;
            bus_busy     <= 1'b1;
            state        <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          wait_cnt <= WAIT_LOAD;
          if (!rd_q && !prot_q) begin
            sram_we_n <= 1'b0;
          end
          state <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (wait_cnt == 4'd0) begin
            if (rd_q) begin
              memory_data_in <= lane_hi_q ? sram_data[15:8] : sram_data[7:0];
            end
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            bus_ready <= 1'b1;
            state     <= ST_RECOVER;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        ST_RECOVER: begin
          sram_ce_n <= 1'b1;
          sram_ub_n <= 1'b1;
          sram_lb_n <= 1'b1;
          drive_en  <= 1'b0;
          bus_busy  <= 1'b0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
